rs_iss_sched: RTL and testbench
===============================

// Module: rs_iss_sched
// PURPOSE
//  Allocation/issue scheduler for the reservation-station entry array.
//  - Picks one free entry per cycle for dispatch.
//  - Per FU class, picks one ready entry using round-robin priority and issues it when that FU accepts.
//  - Drives the per-entry load and iss_en strobes.
//  - Blocks dispatch and issue during branch-recovery squash cycles.
// PARAMETERS
//  RS_NUM   16  number of RS entries
//  FU_NUM   4   FU classes; class k is encoded as fu_sel = k+1 (1=ALU, 2=MULT, 3=MEM, 4=BR)
//  RS_IDX_W $clog2(RS_NUM)  entry index width (derived, not overridable)
// PORTS
//  clk              in   1                 clock
//  rst              in   1                 reset, synchronous, active-high
//  ent_avail_i      in   RS_NUM            per-entry free flag
//  ent_rdy_i        in   RS_NUM            per-entry operands-ready (includes CDB forward)
//  ent_fu_sel_i     in   RS_NUM*FU_SEL_W   per-entry FU class, entry i at [i*FU_SEL_W +: FU_SEL_W]
//  disp_vld_i       in   1                 dispatch stage presents an instruction
//  fu_rdy_i         in   FU_NUM            FU class k accepts an issue this cycle
//  br_recovery_i    in   1                 mispredict squash this cycle
//  ent_load_o       out  RS_NUM            one-hot load strobe to the chosen free entry
//  disp_stall_o     out  1                 dispatch must hold (no free entry, or recovery)
//  ent_iss_en_o     out  RS_NUM            OR of all granted entries this cycle
//  fu_iss_vld_o     out  FU_NUM            class k issues this cycle
//  fu_iss_idx_o     out  FU_NUM*RS_IDX_W   granted entry index per class
//  free_cnt_o       out  RS_IDX_W+1        registered count of free entries
// BEHAVIOUR
//  - All issue/alloc outputs are combinational from inputs and registered state. Zero-cycle latency: a grant in cycle t empties the entry at edge t+1.
//  - Reset (rst=1 at a clock edge): rr_ptr[k]=0 for all k; free_cnt_r=RS_NUM. While rst is high, every *_o except free_cnt_o is forced to 0.
//  - Allocation:
//    - Lowest-index entry with ent_avail_i=1.
//    - ent_load_o is asserted iff disp_vld_i && !br_recovery_i && an entry is free.
//    - disp_stall_o = br_recovery_i || no avail bit set.
//  - Issue request: req[k][i] = ent_rdy_i[i] && !ent_avail_i[i] && ent_fu_sel_i[i] == k+1. An fu_sel of 0 (NONE) or above FU_NUM never requests.
//  - Issue select: for class k, take the first requesting i scanning i = rr_ptr[k], rr_ptr[k]+1, ... modulo RS_NUM.
//  - Issue grant: fu_iss_vld_o[k] = |req[k] && fu_rdy_i[k] && !br_recovery_i. fu_iss_idx_o[k] is 0 when not valid.
//  - Round-robin update: on a grant to entry g, rr_ptr[k] <= (g+1) mod RS_NUM (wraps at RS_NUM-1 to 0). With no grant the pointer holds. fu_rdy_i=0 never advances the pointer.
//  - Classes are disjoint, so one entry is never granted twice. ent_iss_en_o is at most FU_NUM-hot.
//  - Load vs issue: an entry can never see ent_load_o and ent_iss_en_o together, because load requires avail=1 and issue requires avail=0. The bench asserts this.
//  - free_cnt_r is updated every edge:
//    free_cnt_r <= popcount(ent_avail_i) - |ent_load_o + popcount(ent_iss_en_o).
//    Recovery-freed entries are reflected one cycle later through ent_avail_i. The value is saturated to [0, RS_NUM].
//  - br_recovery_i: no load, no issue. rr_ptrs hold. Entries squashed this cycle show avail=1 next cycle.
//  - All entries free: no issue, free_cnt_o = RS_NUM. All entries full: disp_stall_o=1, and issue proceeds normally.
//  - Reset mid-operation: pointers return to 0, and outputs are 0 in the reset cycle.
// STRUCTURE
//  - Shared package (sys_defs): FU_SEL_W, FU_SEL_NONE/ALU/MULT/MEM/BR encodings, RS_NUM default, the fu_class_e typedef.
//  - Sub-module rr_arb (N, IDX_W): request vector + pointer -> one-hot grant, index, valid.
//    - Implemented as a double-width vector masked by the pointer, then a priority encode.
//    - Instantiated FU_NUM times. Allocation reuses a fixed-priority encoder.
// TESTING
//  1. Reset with ent_avail_i=16'hFFFF -> all outputs 0, then free_cnt_o=16. disp_vld_i=1 -> ent_load_o=16'h0001.
//  2. ALU requests on entries 3, 7; fu_rdy_i[0]=1 for 2 cycles -> grants idx 3 then 7. rr_ptr[0]: 4, then 8.
//  3. Wrap: rr_ptr[0]=15, ALU requests on entries 15, 2 -> grant 15, ptr 0. Next cycle grant 2.
//  4. fu_rdy_i[1]=0 with MULT entry 5 ready -> fu_iss_vld_o[1]=0 and ptr holds. Raise fu_rdy_i[1] -> grant 5.
//  5. br_recovery_i=1 with disp_vld_i=1 and 4 ready entries -> ent_load_o=0, ent_iss_en_o=0, disp_stall_o=1.
//  6. Full RS (avail=0) with ALU, MULT, MEM, BR all ready -> 4 simultaneous grants, disp_stall_o=1, free_cnt_o=4 next cycle.

Source files
------------

// File: rtl/rs_iss_sched_pkg.sv
// Shared definitions for the reservation-station scheduler: FU class
// encodings, select-field width and the default entry count.
package rs_iss_sched_pkg;

    localparam int FU_SEL_W   = 3;
    localparam int RS_NUM_DEF = 16;

    // FU class carried in each entry's select field; class k of the
    // scheduler corresponds to encoding k+1, NONE never requests issue.
    typedef enum logic [FU_SEL_W-1:0] {
        FU_SEL_NONE = 3'd0,
        FU_SEL_ALU  = 3'd1,
        FU_SEL_MULT = 3'd2,
        FU_SEL_MEM  = 3'd3,
        FU_SEL_BR   = 3'd4
    } fu_class_e;

endpackage

// File: rtl/rs_iss_sched_rr_arb.sv
// Rotating-priority arbiter: the request vector is unrolled twice, bits
// below the pointer in the lower copy are masked off, and the lowest set
// bit of the result wins. With ptr tied to zero it is a plain
// fixed-priority (lowest index first) encoder.
module rr_arb #(
    parameter int N     = 16,
    parameter int IDX_W = 4
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] idx,
    output logic             vld
);

    logic [2*N-1:0] dbl_s;

    // Build the double-width request vector with positions before ptr removed
    always_comb begin
        dbl_s = '0;
        for (int j = 0; j < 2*N; j++) begin
            dbl_s[j] = req[j % N] && (j >= int'(ptr));
        end
    end

    // Priority-encode the lowest surviving bit and fold it back into [0, N)
    always_comb begin
        vld = 1'b0;
        idx = '0;
        for (int j = 0; j < 2*N; j++) begin
            if (!vld && dbl_s[j]) begin
                vld = 1'b1;
                idx = IDX_W'(j % N);
            end else begin
                idx = idx;
            end
        end
    end

    // Expand the winning index to a one-hot grant
    always_comb begin
        gnt = '0;
        for (int i = 0; i < N; i++) begin
            gnt[i] = vld && (idx == IDX_W'(i));
        end
    end

endmodule

// File: rtl/rs_iss_sched.sv
// Reservation-station allocation and issue scheduler. One free entry is
// picked per cycle for dispatch (lowest index first); each FU class picks
// one ready entry with its own round-robin pointer and issues it when the
// FU accepts. Branch recovery blocks both load and issue for the cycle.
module rs_iss_sched
    import rs_iss_sched_pkg::*;
#(
    parameter  int RS_NUM   = RS_NUM_DEF,
    parameter  int FU_NUM   = 4,
    localparam int RS_IDX_W = $clog2(RS_NUM)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [RS_NUM-1:0]            ent_avail_i,
    input  logic [RS_NUM-1:0]            ent_rdy_i,
    input  logic [RS_NUM*FU_SEL_W-1:0]   ent_fu_sel_i,
    input  logic                         disp_vld_i,
    input  logic [FU_NUM-1:0]            fu_rdy_i,
    input  logic                         br_recovery_i,
    output logic [RS_NUM-1:0]            ent_load_o,
    output logic                         disp_stall_o,
    output logic [RS_NUM-1:0]            ent_iss_en_o,
    output logic [FU_NUM-1:0]            fu_iss_vld_o,
    output logic [FU_NUM*RS_IDX_W-1:0]   fu_iss_idx_o,
    output logic [RS_IDX_W:0]            free_cnt_o
);

    logic [FU_NUM-1:0][RS_IDX_W-1:0] rr_ptr_r;
    logic [FU_NUM-1:0][RS_IDX_W-1:0] rr_ptr_nxt_s;
    logic [FU_NUM-1:0][RS_NUM-1:0]   gnt_s;
    logic [FU_NUM-1:0][RS_IDX_W-1:0] iss_idx_s;
    logic [FU_NUM-1:0]               iss_vld_s;
    logic [RS_NUM-1:0]               iss_en_s;
    logic [RS_NUM-1:0]               ent_load_s;
    logic [RS_NUM-1:0]               alloc_gnt_s;
    logic [RS_IDX_W-1:0]             alloc_idx_s;
    logic                            alloc_vld_s;
    logic                            alloc_unused_s;
    logic                            issue_ok_s;
    logic [RS_IDX_W:0]               free_cnt_r;
    logic [RS_IDX_W:0]               free_nxt_s;
    int                              free_sum_s;

    function automatic int popcnt(input logic [RS_NUM-1:0] v);
        int c;
        c = 0;
        for (int i = 0; i < RS_NUM; i++) begin
            c = c + (v[i] ? 32'sd1 : 32'sd0);
        end
        return c;
    endfunction

    assign issue_ok_s = !rst && !br_recovery_i;

    // Allocation: lowest-index free entry
    rr_arb #(.N(RS_NUM), .IDX_W(RS_IDX_W)) u_alloc (
        .req (ent_avail_i),
        .ptr ({RS_IDX_W{1'b0}}),
        .gnt (alloc_gnt_s),
        .idx (alloc_idx_s),
        .vld (alloc_vld_s)
    );
    assign alloc_unused_s = ^alloc_idx_s;

    assign ent_load_s   = (issue_ok_s && disp_vld_i) ? alloc_gnt_s : '0;
    assign disp_stall_o = !rst && (br_recovery_i || !alloc_vld_s);
    assign ent_load_o   = ent_load_s;

    for (genvar k = 0; k < FU_NUM; k++) begin : g_fu
        logic [RS_NUM-1:0]   req_s;
        logic [RS_NUM-1:0]   arb_gnt_s;
        logic [RS_IDX_W-1:0] arb_idx_s;
        logic                arb_vld_s;

        // An entry requests its class once occupied, ready and tagged k+1
        always_comb begin
            req_s = '0;
            for (int i = 0; i < RS_NUM; i++) begin
                req_s[i] = ent_rdy_i[i] && !ent_avail_i[i] &&
                           (ent_fu_sel_i[i*FU_SEL_W +: FU_SEL_W] == FU_SEL_W'(k + 1));
            end
        end

        rr_arb #(.N(RS_NUM), .IDX_W(RS_IDX_W)) u_arb (
            .req (req_s),
            .ptr (rr_ptr_r[k]),
            .gnt (arb_gnt_s),
            .idx (arb_idx_s),
            .vld (arb_vld_s)
        );

        assign iss_vld_s[k] = issue_ok_s && arb_vld_s && fu_rdy_i[k];
        assign gnt_s[k]     = iss_vld_s[k] ? arb_gnt_s : '0;
        assign iss_idx_s[k] = iss_vld_s[k] ? arb_idx_s : '0;
    end

    // Merge per-class grants into the entry issue strobe
    always_comb begin
        iss_en_s = '0;
        for (int k = 0; k < FU_NUM; k++) begin
            iss_en_s = iss_en_s | gnt_s[k];
        end
    end

    assign ent_iss_en_o = iss_en_s;
    assign fu_iss_vld_o = iss_vld_s;
    assign fu_iss_idx_o = iss_idx_s;

    // Pointer moves just past a granted entry; otherwise it holds
    always_comb begin
        rr_ptr_nxt_s = rr_ptr_r;
        for (int k = 0; k < FU_NUM; k++) begin
            if (iss_vld_s[k]) begin
                rr_ptr_nxt_s[k] = (iss_idx_s[k] == RS_IDX_W'(RS_NUM - 1)) ?
                                  '0 : iss_idx_s[k] + RS_IDX_W'(1);
            end else begin
                rr_ptr_nxt_s[k] = rr_ptr_r[k];
            end
        end
    end

    // Round-robin pointer state
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_r <= '0;
        end else begin
            rr_ptr_r <= rr_ptr_nxt_s;
        end
    end

    // Free count after this cycle's load and issues, clamped to [0, RS_NUM]
    always_comb begin
        free_sum_s = popcnt(ent_avail_i) - ((|ent_load_s) ? 32'sd1 : 32'sd0) + popcnt(iss_en_s);
        if (free_sum_s < 32'sd0) begin
            free_nxt_s = '0;
        end else if (free_sum_s > RS_NUM) begin
            free_nxt_s = (RS_IDX_W + 1)'(RS_NUM);
        end else begin
            free_nxt_s = (RS_IDX_W + 1)'(free_sum_s);
        end
    end

    // Registered free-entry count
    always_ff @(posedge clk) begin
        if (rst) begin
            free_cnt_r <= (RS_IDX_W + 1)'(RS_NUM);
        end else begin
            free_cnt_r <= free_nxt_s;
        end
    end

    assign free_cnt_o = free_cnt_r;

endmodule

// File: tb/tb_rs_iss_sched.sv
// Bench for rs_iss_sched: a per-cycle scheduling model built from the
// allocation/issue rules is compared against the DUT on every falling
// edge, and directed scenarios pin key results with literal values.
module tb_rs_iss_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] ent_avail_i;
    logic [15:0] ent_rdy_i;
    logic [47:0] sel_v;
    logic        disp_vld_i;
    logic [3:0]  fu_rdy_i;
    logic        br_recovery_i;
    logic [15:0] ent_load_o;
    logic        disp_stall_o;
    logic [15:0] ent_iss_en_o;
    logic [3:0]  fu_iss_vld_o;
    logic [15:0] fu_iss_idx_o;
    logic [4:0]  free_cnt_o;

    int total = 0;
    int bad   = 0;

    // model state
    int mptr[4];
    int nxt_ptr[4];
    int mfc;
    int nxt_fc;
    bit mvalid = 1'b0;

    rs_iss_sched dut (
        .clk           (clk),
        .rst           (rst),
        .ent_avail_i   (ent_avail_i),
        .ent_rdy_i     (ent_rdy_i),
        .ent_fu_sel_i  (sel_v),
        .disp_vld_i    (disp_vld_i),
        .fu_rdy_i      (fu_rdy_i),
        .br_recovery_i (br_recovery_i),
        .ent_load_o    (ent_load_o),
        .disp_stall_o  (disp_stall_o),
        .ent_iss_en_o  (ent_iss_en_o),
        .fu_iss_vld_o  (fu_iss_vld_o),
        .fu_iss_idx_o  (fu_iss_idx_o),
        .free_cnt_o    (free_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_sel(input int i, input logic [2:0] v);
        sel_v[i*3 +: 3] = v;
    endtask

    // Model: derive this cycle's expected outputs and next state, then compare
    always @(negedge clk) begin
        logic [15:0] e_load;
        logic [15:0] e_iss;
        logic [3:0]  e_vld;
        logic [15:0] e_idx;
        logic        e_stall;
        int          first_free;
        int          g;
        int          e;
        int          cnt;
        e_load  = '0;
        e_iss   = '0;
        e_vld   = '0;
        e_idx   = '0;
        e_stall = 1'b0;
        for (int k = 0; k < 4; k++) nxt_ptr[k] <= mptr[k];
        if (!rst) begin
            first_free = -1;
            for (int i = 0; i < 16; i++)
                if (first_free < 0 && ent_avail_i[i]) first_free = i;
            e_stall = br_recovery_i || (first_free < 0);
            if (disp_vld_i && !br_recovery_i && first_free >= 0) e_load[first_free] = 1'b1;
            for (int k = 0; k < 4; k++) begin
                g = -1;
                if (fu_rdy_i[k] && !br_recovery_i) begin
                    for (int off = 0; off < 16; off++) begin
                        e = (mptr[k] + off) % 16;
                        if (g < 0 && ent_rdy_i[e] && !ent_avail_i[e] && sel_v[e*3 +: 3] == 3'(k + 1))
                            g = e;
                    end
                end
                if (g >= 0) begin
                    e_vld[k]         = 1'b1;
                    e_idx[k*4 +: 4]  = 4'(g);
                    e_iss[g]         = 1'b1;
                    nxt_ptr[k]      <= (g + 1) % 16;
                end
            end
        end
        cnt = $countones(ent_avail_i) - ((e_load != 16'd0) ? 1 : 0) + $countones(e_iss);
        nxt_fc <= (cnt < 0) ? 0 : ((cnt > 16) ? 16 : cnt);

        chk("load",       64'(ent_load_o),   64'(e_load));
        chk("stall",      64'(disp_stall_o), 64'(e_stall));
        chk("iss_en",     64'(ent_iss_en_o), 64'(e_iss));
        chk("fu_vld",     64'(fu_iss_vld_o), 64'(e_vld));
        chk("fu_idx",     64'(fu_iss_idx_o), 64'(e_idx));
        chk("load_iss_excl", 64'(ent_load_o & ent_iss_en_o), 64'd0);
        if (mvalid) chk("free_cnt", 64'(free_cnt_o), 64'(mfc));
    end

    // Model: commit state at the clock edge
    always @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < 4; k++) mptr[k] <= 0;
            mfc    <= 16;
            mvalid <= 1'b1;
        end else begin
            for (int k = 0; k < 4; k++) mptr[k] <= nxt_ptr[k];
            mfc <= nxt_fc;
        end
    end

    initial begin
        rst = 1'b1; ent_avail_i = 16'hFFFF; ent_rdy_i = 16'h0000; sel_v = 48'd0;
        disp_vld_i = 1'b1; fu_rdy_i = 4'b0000; br_recovery_i = 1'b0;
        #2;
        chk("rst_load", 64'(ent_load_o), 64'd0);
        chk("rst_stall", 64'(disp_stall_o), 64'd0);
        tick(); tick();
        rst = 1'b0;
        #1;
        chk("t1_load", 64'(ent_load_o), 64'h0001);
        chk("t1_free", 64'(free_cnt_o), 64'd16);

        // ALU round robin 3 then 7
        tick();
        disp_vld_i = 1'b0; ent_avail_i = 16'hFF77; ent_rdy_i = 16'h0088;
        set_sel(3, 3'd1); set_sel(7, 3'd1); fu_rdy_i = 4'b0001;
        #1;
        chk("t2_idx3", 64'(fu_iss_idx_o[3:0]), 64'd3);
        chk("t2_en3",  64'(ent_iss_en_o), 64'h0008);
        tick();
        ent_avail_i = 16'hFF7F; ent_rdy_i = 16'h0080;
        #1;
        chk("t2_idx7", 64'(fu_iss_idx_o[3:0]), 64'd7);
        chk("t2_free", 64'(free_cnt_o), 64'd15);
        tick();
        ent_avail_i = 16'hFFFF; ent_rdy_i = 16'h0000; set_sel(3, 3'd0); set_sel(7, 3'd0);
        #1;
        chk("t2_mptr", 64'(mptr[0]), 64'd8);
        chk("t2_free2", 64'(free_cnt_o), 64'd16);

        // wrap at entry 15
        ent_avail_i = 16'hBFFF; ent_rdy_i = 16'h4000; set_sel(14, 3'd1);
        #1;
        chk("t3_idx14", 64'(fu_iss_idx_o[3:0]), 64'd14);
        tick();
        ent_avail_i = 16'h7FFB; ent_rdy_i = 16'h8004;
        set_sel(14, 3'd0); set_sel(15, 3'd1); set_sel(2, 3'd1);
        #1;
        chk("t3_idx15", 64'(fu_iss_idx_o[3:0]), 64'd15);
        tick();
        ent_avail_i = 16'hFFFB; ent_rdy_i = 16'h0004; set_sel(15, 3'd0);
        #1;
        chk("t3_idx2", 64'(fu_iss_idx_o[3:0]), 64'd2);
        tick();
        ent_avail_i = 16'hFFFF; ent_rdy_i = 16'h0000; sel_v = 48'd0; fu_rdy_i = 4'b0000;

        // MULT blocked by fu_rdy, then granted, then pointer past 5
        ent_avail_i = 16'hFFDF; ent_rdy_i = 16'h0020; set_sel(5, 3'd2);
        #1;
        chk("t4_blk_vld", 64'(fu_iss_vld_o), 64'd0);
        tick();
        #1;
        chk("t4_blk_en", 64'(ent_iss_en_o), 64'd0);
        tick();
        fu_rdy_i = 4'b0010;
        #1;
        chk("t4_vld", 64'(fu_iss_vld_o), 64'b0010);
        chk("t4_idx5", 64'(fu_iss_idx_o[7:4]), 64'd5);
        tick();
        ent_avail_i = 16'hFDFB; ent_rdy_i = 16'h0204;
        set_sel(5, 3'd0); set_sel(2, 3'd2); set_sel(9, 3'd2);
        #1;
        chk("t4_idx9", 64'(fu_iss_idx_o[7:4]), 64'd9);
        tick();
        ent_avail_i = 16'hFFFF; ent_rdy_i = 16'h0000; sel_v = 48'd0; fu_rdy_i = 4'b0000;

        // branch recovery blocks everything
        br_recovery_i = 1'b1; disp_vld_i = 1'b1; ent_avail_i = 16'hFFF0; ent_rdy_i = 16'h000F;
        set_sel(0, 3'd1); set_sel(1, 3'd2); set_sel(2, 3'd3); set_sel(3, 3'd4); fu_rdy_i = 4'b1111;
        #1;
        chk("t5_load", 64'(ent_load_o), 64'd0);
        chk("t5_en",   64'(ent_iss_en_o), 64'd0);
        chk("t5_stall", 64'(disp_stall_o), 64'd1);
        tick();

        // full RS, all four classes issue; sel 5 and sel 0 never request
        br_recovery_i = 1'b0; ent_avail_i = 16'h0000; ent_rdy_i = 16'h030F; set_sel(8, 3'd5);
        #1;
        chk("t6_vld", 64'(fu_iss_vld_o), 64'hF);
        chk("t6_en",  64'(ent_iss_en_o), 64'h000F);
        chk("t6_stall", 64'(disp_stall_o), 64'd1);
        chk("t6_idx", 64'(fu_iss_idx_o), 64'h3210);
        tick();
        #1;
        chk("t6_free", 64'(free_cnt_o), 64'd4);

        // reset mid-operation returns pointers to 0
        sel_v = 48'd0; set_sel(0, 3'd1); set_sel(12, 3'd1);
        ent_rdy_i = 16'h1001; fu_rdy_i = 4'b0001; rst = 1'b1;
        #1;
        chk("t7_rst_en", 64'(ent_iss_en_o), 64'd0);
        chk("t7_rst_stall", 64'(disp_stall_o), 64'd0);
        tick();
        rst = 1'b0;
        #1;
        chk("t7_idx0", 64'(fu_iss_idx_o[3:0]), 64'd0);
        chk("t7_free", 64'(free_cnt_o), 64'd16);
        tick();
        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
